// File: rtl/uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
//
// Serial UART transmitter. A byte presented with tx_en_i while the block is
// idle is latched and sent as one asynchronous frame on tx_o:
// start bit (0), 8 data bits LSB first, optional even parity bit, stop bit (1).
// Every output is registered, so tx_o drops to the start level on the same
// edge that accepts the byte.
//
// Optional feature:
//   UART_TX_PARITY_EN - when defined, an even parity bit (XOR of the 8 data
//                       bits) is sent between the last data bit and the stop
//                       bit, giving an 11-bit frame. Undefined: 10-bit frame.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (2..65535)
//   CNT_W        - bit-period counter width, 2**CNT_W > CLKS_PER_BIT
//
// Ports:
//   clk_i       system clock
//   rst_i       asynchronous active-high reset; abandons any frame in flight
//   tx_data_i   byte to send, sampled only on the accept edge
//   tx_en_i     transmit request (pulse or level); ignored while busy
//   tx_busy_o   high for the whole frame
//   tx_done_o   one-cycle pulse when the stop bit period completes
//   tx_o        serial line, idle high
// ---------------------------------------------------------------------------
module uart_tx_byte #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_en_i,
    output logic       tx_busy_o,
    output logic       tx_done_o,
    output logic       tx_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

`ifdef UART_TX_PARITY_EN
    // Even parity: the transmitted bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end_s;

    assign bit_end_s = (cnt_q == CNT_LAST);

    // State and output registers; reset parks the line high and idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= CNT_ZERO;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic; tx_d is the level the line carries from the next edge.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        // The period counter restarts at every bit boundary so it never
        // runs past CLKS_PER_BIT-1.
        if (bit_end_s) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d     = CNT_ZERO;
                bit_idx_d = 3'd0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
                if (tx_en_i) begin
                    shift_d = tx_data_i;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end else begin
                    tx_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = even_parity(shift_q);
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    tx_d = shift_q[bit_idx_q];
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end else begin
                    tx_d = tx_q;
                end
            end
`endif
            ST_STOP: begin
                tx_d = 1'b1;
                if (bit_end_s) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                // Unreachable encodings recover to a quiet idle line.
                state_d   = ST_IDLE;
                cnt_d     = CNT_ZERO;
                bit_idx_d = 3'd0;
                tx_d      = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    assign tx_o      = tx_q;
    assign tx_busy_o = busy_q;
    assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_byte
//
// Self-checking bench for uart_tx_byte with CLKS_PER_BIT=4. Each accepted
// byte pushes its expected serial frame onto a scoreboard queue; a line
// monitor detects each start bit, samples every cycle of the frame, and
// compares bits, busy length and the done pulse against the popped entry.
// Build with +define+UART_TX_PARITY_EN to exercise the parity frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_byte;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_busy;
    logic       tx_done;
    logic       tx;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int starts_seen = 0;
    int frames_done = 0;
    int spurious_done = 0;
    int last_start = 0;
    int prev_start = 0;
    bit mon_active = 1'b0;

    logic [10:0] sb_q[$];

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;
    vec_t vecs[10];

    uart_tx_byte #(
        .CLKS_PER_BIT(CPB),
        .CNT_W(16)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .tx_data_i(tx_data),
        .tx_en_i  (tx_en),
        .tx_busy_o(tx_busy),
        .tx_done_o(tx_done),
        .tx_o     (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame as transmitted, bit i = i-th bit on the line.
    function automatic logic [10:0] make_frame(input logic [7:0] d, input logic p);
        logic [10:0] f;
        f = 11'd0;
        f[0] = 1'b0;
        f[8:1] = d;
        if (NBITS == 11) f[9] = p;
        f[NBITS-1] = 1'b1;
        return f;
    endfunction

    // Line monitor / scoreboard consumer.
    initial begin : monitor
        logic [10:0] exp_f;
        logic [10:0] got_f;
        bit exp_valid;
        bit glitch;
        bit busy_ok;
        int mcyc;
        exp_f = 11'd0; got_f = 11'd0; exp_valid = 1'b0;
        glitch = 1'b0; busy_ok = 1'b1; mcyc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && tx === 1'b0) begin
                    chk("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
                    exp_valid = (sb_q.size() != 0);
                    if (exp_valid) exp_f = sb_q.pop_front();
                    else exp_f = 11'd0;
                    got_f = 11'd0; glitch = 1'b0; busy_ok = 1'b1; mcyc = 0;
                    mon_active = 1'b1;
                    prev_start = last_start;
                    last_start = cyc;
                    starts_seen++;
                end
                if (mon_active) begin
                    if (mcyc < FRAME_CYC) begin
                        if (mcyc % CPB == 0) got_f[mcyc / CPB] = tx;
                        else if (tx !== got_f[mcyc / CPB]) glitch = 1'b1;
                        if (tx_busy !== 1'b1) busy_ok = 1'b0;
                        if (tx_done !== 1'b0) spurious_done++;
                        mcyc++;
                    end else begin
                        if (exp_valid) chk("frame_bits", 32'(got_f), 32'(exp_f));
                        chk("bit_stable", 32'(glitch), 32'd0);
                        chk("busy_held", 32'(busy_ok), 32'd1);
                        chk("busy_falls", 32'(tx_busy), 32'd0);
                        chk("done_pulse", 32'(tx_done), 32'd1);
                        chk("stop_high", 32'(tx), 32'd1);
                        mon_active = 1'b0;
                        frames_done++;
                    end
                end else if (tx_done !== 1'b0) begin
                    spurious_done++;
                end
            end
        end
    end

    task automatic send_pulse(input logic [7:0] d, input logic p);
        @(negedge clk);
        tx_data = d;
        tx_en = 1'b1;
        sb_q.push_back(make_frame(d, p));
        @(negedge clk);
        tx_en = 1'b0;
    endtask

    task automatic wait_idle(input bit scramble);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            if (scramble) tx_data = 8'($urandom);
            n++;
        end while ((tx_busy || mon_active) && n < 500);
        chk("idle_timeout", 32'(n >= 500), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : main
        int base;
        int n;
        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'hA3, 1'b0};
        vecs[2] = '{8'h00, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h07, 1'b1};
        vecs[5] = '{8'h03, 1'b0};
        vecs[6] = '{8'h81, 1'b0};
        vecs[7] = '{8'h3C, 1'b0};
        vecs[8] = '{8'h01, 1'b1};
        vecs[9] = '{8'h80, 1'b1};

        rst = 1'b0; tx_en = 1'b0; tx_data = 8'h00;
        #1 rst = 1'b1;
        #1;
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_busy", 32'(tx_busy), 32'd0);
        chk("reset_done", 32'(tx_done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven single frames.
        for (int i = 0; i < 10; i++) begin
            send_pulse(vecs[i].data, vecs[i].par);
            wait_idle(1'b0);
        end

        // Request while busy must be dropped.
        base = starts_seen;
        send_pulse(8'hA3, 1'b0);
        repeat (9) @(negedge clk);
        tx_data = 8'hFF;
        tx_en = 1'b1;
        @(negedge clk);
        tx_en = 1'b0;
        wait_idle(1'b0);
        repeat (20) @(negedge clk);
        chk("ignore_one_frame", 32'(starts_seen - base), 32'd1);
        chk("ignore_sb_empty", 32'(sb_q.size()), 32'd0);
        chk("ignore_line_idle", 32'(tx), 32'd1);

        // Back-to-back with tx_en held high.
        base = starts_seen;
        @(negedge clk);
        tx_data = 8'h00;
        tx_en = 1'b1;
        sb_q.push_back(make_frame(8'h00, 1'b0));
        @(negedge clk);
        tx_data = 8'h01;
        sb_q.push_back(make_frame(8'h01, 1'b1));
        n = 0;
        while (starts_seen < base + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tx_en = 1'b0;
        chk("b2b_timeout", 32'(n >= 200), 32'd0);
        chk("b2b_gap", 32'(last_start - prev_start), 32'(FRAME_CYC + 1));
        wait_idle(1'b0);

        // Data changes after accept must not reach the line.
        send_pulse(8'h81, 1'b0);
        wait_idle(1'b1);
        tx_data = 8'h00;

        // Asynchronous reset during data bit 3.
        send_pulse(8'h5A, 1'b0);
        repeat (17) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_tx", 32'(tx), 32'd1);
        chk("rst_async_busy", 32'(tx_busy), 32'd0);
        chk("rst_async_done", 32'(tx_done), 32'd0);
        repeat (2) @(negedge clk);
        sb_q.delete();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_pulse(8'h3C, 1'b0);
        wait_idle(1'b0);

        repeat (5) @(negedge clk);
        chk("spurious_done", 32'(spurious_done), 32'd0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("frames_done", 32'(frames_done), 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
